// File: rtl/ascii_scroll_display.sv
// ASCII message buffer with 7-segment glyph decode and an auto-scrolling
// NUM_DIGITS-wide window on registered active-low HEX outputs.
module ascii_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [7:0]                       wr_data,
    input  logic                             clear,
    input  logic                             scroll_en,
    output logic [7*NUM_DIGITS-1:0]          hex_o,
    output logic [$clog2(MSG_DEPTH+1)-1:0]   count,
    output logic                             full,
    output logic                             overflow
);

    localparam int CW = $clog2(MSG_DEPTH + 1);
    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(MSG_DEPTH);

    typedef enum logic [1:0] {
        STATIC,
        SCROLL_WAIT,
        SCROLL_STEP
    } state_t;

    state_t                  state, state_nxt;
    logic [7:0]              msg_mem [MSG_DEPTH];
    logic [CW-1:0]           pos_q, pos_nxt;
    logic [TW-1:0]           tick_q, tick_nxt;
    logic [CW-1:0]           count_nxt;
    logic                    wr_ok;
    logic                    scroll_mode;
    logic                    scroll_ok;
    logic                    advance;
    logic [7*NUM_DIGITS-1:0] window;
    logic [31:0]             idx;
    logic [31:0]             cnt;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            8'h30: return 7'h40;
            8'h31: return 7'h79;
            8'h32: return 7'h24;
            8'h33: return 7'h30;
            8'h34: return 7'h19;
            8'h35: return 7'h12;
            8'h36: return 7'h02;
            8'h37: return 7'h78;
            8'h38: return 7'h00;
            8'h39: return 7'h10;
            8'h41: return 7'h08;
            8'h42: return 7'h03;
            8'h43: return 7'h46;
            8'h44: return 7'h21;
            8'h45: return 7'h06;
            8'h46: return 7'h0E;
            8'h47: return 7'h42;
            8'h48: return 7'h09;
            8'h49: return 7'h4F;
            8'h4A: return 7'h61;
            8'h4B: return 7'h0A;
            8'h4C: return 7'h47;
            8'h4D: return 7'h48;
            8'h4E: return 7'h2B;
            8'h4F: return 7'h23;
            8'h50: return 7'h0C;
            8'h51: return 7'h18;
            8'h52: return 7'h2F;
            8'h53: return 7'h12;
            8'h54: return 7'h07;
            8'h55: return 7'h41;
            8'h56: return 7'h63;
            8'h57: return 7'h2A;
            8'h58: return 7'h09;
            8'h59: return 7'h11;
            8'h5A: return 7'h24;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        wr_ok       = wr_en && !clear && !full;
        count_nxt   = clear ? '0 : (wr_ok ? count + CW'(1) : count);
        scroll_mode = int'(count) > NUM_DIGITS;
        scroll_ok   = scroll_mode && scroll_en && !clear;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STATIC;
        else        state <= state_nxt;
    end

    // Next state: SCROLL_STEP is entered for the cycle whose edge is the terminal tick
    always_comb begin
        state_nxt = STATIC;
        if (scroll_ok) begin
            if (tick_nxt == TICK_LAST) state_nxt = SCROLL_STEP;
            else                       state_nxt = SCROLL_WAIT;
        end
    end

    // Outputs of the FSM: step strobe and next tick/pos values
    always_comb begin
        advance  = scroll_ok && ((state == SCROLL_STEP) || (TICK_DIV == 1));
        tick_nxt = (!scroll_ok || advance) ? '0 : tick_q + TW'(1);
        pos_nxt  = pos_q;
        if (clear || !scroll_mode) pos_nxt = '0;
        else if (advance)          pos_nxt = (pos_q == count) ? '0 : pos_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            pos_q    <= '0;
            tick_q   <= '0;
            hex_o    <= '1;
        end else begin
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH_C);
            overflow <= clear ? 1'b0 : (overflow | (wr_en & full));
            pos_q    <= pos_nxt;
            tick_q   <= tick_nxt;
            hex_o    <= window;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) msg_mem[AW'(count)] <= wr_data;
    end

    // Walk the virtual message from pos; the separator wrap only applies in scroll mode,
    // so static text stays left-justified with blank padding.
    always_comb begin
        window = '1;
        cnt    = 32'(count);
        idx    = 32'(pos_q);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (idx < cnt)
                window[7*(NUM_DIGITS-1-j) +: 7] = glyph(msg_mem[AW'(idx)]);
            if (scroll_mode && idx == cnt) idx = '0;
            else                           idx = idx + 32'd1;
        end
    end

endmodule

// File: tb/tb_ascii_scroll_display.sv
// Directed bench for ascii_scroll_display: reset, static text, scroll wrap,
// freeze/resume, full/overflow, clear priority and async reset mid-scroll.
module tb_ascii_scroll_display;

    localparam int ND    = 4;
    localparam int DEPTH = 8;
    localparam int TD    = 4;

    localparam logic [6:0] GA = 7'h08;
    localparam logic [6:0] G0 = 7'h40;
    localparam logic [6:0] GH = 7'h09;
    localparam logic [6:0] GE = 7'h06;
    localparam logic [6:0] G1 = 7'h79;
    localparam logic [6:0] GB = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clear = 1'b0;
    logic        scroll_en = 1'b0;
    logic [27:0] hex_o;
    logic [3:0]  count;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [27:0] win [7];

    ascii_scroll_display #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (DEPTH),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clear     (clear),
        .scroll_en (scroll_en),
        .hex_o     (hex_o),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] c);
        wr_en   = 1'b1;
        wr_data = c;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        win[0] = {GA, G0, GH, GE};
        win[1] = {G0, GH, GE, G1};
        win[2] = {GH, GE, G1, GB};
        win[3] = {GE, G1, GB, GA};
        win[4] = {G1, GB, GA, G0};
        win[5] = {GB, GA, G0, GH};
        win[6] = {GA, G0, GH, GE};

        // Reset
        cyc();
        cyc();
        chk("rst_hex", 32'(hex_o), 32'h0FFFFFFF);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("idle_hex", 32'(hex_o), 32'h0FFFFFFF);
        chk("idle_count", 32'(count), 0);

        // Static
        scroll_en = 1'b1;
        wr("H");
        wr("E");
        chk("static_count", 32'(count), 2);
        cyc();
        chk("static_hex", 32'(hex_o), 32'({GH, GE, GB, GB}));
        repeat (20) cyc();
        chk("static_hold", 32'(hex_o), 32'({GH, GE, GB, GB}));

        // Scroll wrap
        clr();
        chk("clr_count", 32'(count), 0);
        wr("A");
        wr("0");
        wr("H");
        wr("E");
        wr("1");
        chk("scroll_count", 32'(count), 5);
        cyc();
        chk("win0", 32'(hex_o), 32'(win[0]));
        for (int k = 1; k < 7; k++) begin
            repeat (3) cyc();
            chk("pre_step", 32'(hex_o), 32'(win[k-1]));
            cyc();
            chk($sformatf("win%0d", k), 32'(hex_o), 32'(win[k]));
        end

        // Freeze mid-period, then resume
        cyc();
        cyc();
        scroll_en = 1'b0;
        repeat (10) cyc();
        chk("frozen", 32'(hex_o), 32'(win[0]));
        scroll_en = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("resume_pre", 32'(hex_o), 32'(win[0]));
        cyc();
        chk("resume_step", 32'(hex_o), 32'(win[1]));

        // Full / overflow
        scroll_en = 1'b0;
        clr();
        wr(8'h61);
        wr(8'h23);
        wr("H");
        wr("E");
        wr("0");
        wr("1");
        wr("A");
        chk("cnt7", 32'(count), 7);
        chk("full7", 32'(full), 0);
        wr("E");
        chk("cnt8", 32'(count), 8);
        chk("full8", 32'(full), 1);
        chk("ovf8", 32'(overflow), 0);
        cyc();
        chk("full_hex", 32'(hex_o), 32'({GA, GB, GH, GE}));
        wr("1");
        chk("cnt9", 32'(count), 8);
        chk("ovf9", 32'(overflow), 1);
        repeat (3) cyc();
        chk("ovf_hold", 32'(overflow), 1);
        chk("full_hold", 32'(full), 1);

        // Clear has priority over a write
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = "A";
        cyc();
        clear   = 1'b0;
        wr_en   = 1'b0;
        chk("cp_count", 32'(count), 0);
        chk("cp_full", 32'(full), 0);
        chk("cp_ovf", 32'(overflow), 0);
        cyc();
        chk("cp_hex", 32'(hex_o), 32'h0FFFFFFF);

        // Async reset mid-scroll
        scroll_en = 1'b1;
        wr("H");
        wr("E");
        wr("0");
        wr("1");
        wr("A");
        cyc();
        cyc();
        chk("ar_pre", 32'(hex_o), 32'({GH, GE, G0, G1}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_hex", 32'(hex_o), 32'h0FFFFFFF);
        chk("ar_count", 32'(count), 0);
        chk("ar_full", 32'(full), 0);
        chk("ar_ovf", 32'(overflow), 0);
        #2;
        rst_n = 1'b1;
        wr("E");
        chk("ar_cnt1", 32'(count), 1);
        cyc();
        chk("ar_first", 32'(hex_o), 32'({GE, GB, GB, GB}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
